// File: rtl/vga_fetch_pkg.sv
// Shared types and AXI constants for the VGA frame-fetch AXI master.
// Contents: FSM state enum, AXI encodings, and a helper that maps a
// bus width in bytes to the AXI ARSIZE encoding.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } fetch_state_e;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // ARSIZE is log2 of the beat size in bytes.
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/vga_axi_ar_issue.sv
// AR-channel issue engine: holds the burst address, the burst counter and
// the outstanding-burst counter, and keeps ARVALID/ARADDR stable once raised.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   load_i            - accepted frame start: load base, clear counters
//   base_addr_i       - frame base address loaded on load_i
//   issue_i           - top-level FSM is in the issue state
//   ar_ready_i        - ARREADY from the interconnect
//   r_last_hs_i       - R handshake carrying RLAST (retires one burst)
//   araddr_o          - current burst address
//   arvalid_o         - ARVALID
//   last_ar_hs_o      - AR handshake of the final burst of the frame
//   outstanding_o     - bursts issued but not yet retired
module vga_axi_ar_issue
    import vga_fetch_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned BURST_BYTES     = 128,
    parameter int unsigned N_BURSTS        = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned OCW             = $clog2(MAX_OUTSTANDING + 1),
    parameter logic [AXI_ADDR_WIDTH-1:0] RST_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr_i,
    input  logic                      issue_i,
    input  logic                      ar_ready_i,
    input  logic                      r_last_hs_i,
    output logic [AXI_ADDR_WIDTH-1:0] araddr_o,
    output logic                      arvalid_o,
    output logic                      last_ar_hs_o,
    output logic [OCW-1:0]            outstanding_o
);

    localparam int unsigned BCW = $clog2(N_BURSTS + 1);

    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BCW-1:0]            burst_q, burst_d;
    logic [OCW-1:0]            outst_q, outst_d;
    logic                      pend_q, pend_d;
    logic                      arvalid, ar_hs;

    always_comb begin
        // pend_q keeps ARVALID up after it was offered, whatever else changes.
        arvalid = pend_q | (issue_i & (outst_q < OCW'(MAX_OUTSTANDING)));
        ar_hs   = arvalid & ar_ready_i;
        addr_d  = addr_q;
        burst_d = burst_q;
        outst_d = outst_q;
        pend_d  = arvalid & ~ar_ready_i;
        if (load_i) begin
            addr_d  = base_addr_i;
            burst_d = '0;
            outst_d = '0;
            pend_d  = 1'b0;
        end else begin
            if (ar_hs) begin
                addr_d  = addr_q + AXI_ADDR_WIDTH'(BURST_BYTES);
                burst_d = burst_q + BCW'(1);
            end
            case ({ar_hs, r_last_hs_i})
                2'b10:   outst_d = outst_q + OCW'(1);
                2'b01:   outst_d = outst_q - OCW'(1);
                default: outst_d = outst_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= RST_ADDR;
            burst_q <= '0;
            outst_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            burst_q <= burst_d;
            outst_q <= outst_d;
            pend_q  <= pend_d;
        end
    end

    assign araddr_o      = addr_q;
    assign arvalid_o     = arvalid;
    assign last_ar_hs_o  = ar_hs & (burst_q == BCW'(N_BURSTS - 1));
    assign outstanding_o = outst_q;

endmodule

// File: rtl/vga_axi_burst_fetch.sv
// AXI4 INCR burst-read master fetching one video frame per frame_start_i
// pulse and streaming it, with backpressure, to the VGA line FIFO.
// Optional feature macro: VGA_FETCH_DBL_BUF_EN (alternating frame buffers).
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   frame_start_i            - single-cycle frame fetch request
//   m_ar*                    - AXI AR channel (master side)
//   m_r*                     - AXI R channel (master side)
//   pix_data_o/valid_o/rdy_i - pixel word stream; pix_last_o marks the frame's last word
//   busy_o                   - frame fetch in progress
//   resp_err_o               - sticky RRESP/RLAST error, cleared on accepted start
//   frame_overrun_o          - pulse: start request arrived while busy
//   buf_sel_o                - frame buffer being fetched
module vga_axi_burst_fetch
    import vga_fetch_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned H_PIXELS        = 640,
    parameter int unsigned V_LINES         = 480,
    parameter int unsigned PXL_BITS        = 16,
    parameter logic [AXI_ADDR_WIDTH-1:0] FB_BASE_ADDR  = 32'h8000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] FB_ALT_OFFSET = 32'h0010_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start_i,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
    output logic [7:0]                m_arlen_o,
    output logic [2:0]                m_arsize_o,
    output logic [1:0]                m_arburst_o,
    output logic [2:0]                m_arprot_o,
    output logic                      m_arvalid_o,
    input  logic                      m_arready_i,
    input  logic [AXI_DATA_WIDTH-1:0] m_rdata_i,
    input  logic [1:0]                m_rresp_i,
    input  logic                      m_rlast_i,
    input  logic                      m_rvalid_i,
    output logic                      m_rready_o,
    output logic [AXI_DATA_WIDTH-1:0] pix_data_o,
    output logic                      pix_valid_o,
    input  logic                      pix_rdy_i,
    output logic                      pix_last_o,
    output logic                      busy_o,
    output logic                      resp_err_o,
    output logic                      frame_overrun_o,
    output logic                      buf_sel_o
);

    localparam int unsigned BYTES       = AXI_DATA_WIDTH / 8;
    localparam int unsigned FRAME_WORDS = H_PIXELS * V_LINES * PXL_BITS / AXI_DATA_WIDTH;
    localparam int unsigned N_BURSTS    = FRAME_WORDS / BURST_LEN;
    localparam int unsigned BURST_BYTES = BURST_LEN * BYTES;
    localparam int unsigned BW          = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned OCW         = $clog2(MAX_OUTSTANDING + 1);

    if ((FRAME_WORDS % BURST_LEN) != 0 || N_BURSTS == 0) begin : g_chk_words
        $error("frame must be a nonzero whole number of bursts");
    end
    if ((4096 % BURST_BYTES) != 0) begin : g_chk_4k
        $error("burst size must divide 4096 so bursts never cross a 4 KiB page");
    end
    if ((FB_BASE_ADDR % BURST_BYTES) != 0 || (FB_ALT_OFFSET % BURST_BYTES) != 0) begin : g_chk_align
        $error("frame buffers must be aligned to the burst size");
    end

    fetch_state_e              state_q, state_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic                      resp_err_q, resp_err_d;
    logic                      overrun_q, overrun_d;
    logic                      buf_sel_q, buf_sel_d;
    logic [AXI_ADDR_WIDTH-1:0] base_addr;
    logic                      busy, start_ok, r_hs, r_last_hs, beat_last, last_ar_hs;
    logic [OCW-1:0]            outstanding;

    assign busy      = (state_q != StIdle);
    assign start_ok  = frame_start_i & ~busy;
    assign r_hs      = m_rvalid_i & m_rready_o;
    assign r_last_hs = r_hs & m_rlast_i;
    assign beat_last = (beat_q == BW'(BURST_LEN - 1));

    vga_axi_ar_issue #(
        .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
        .BURST_BYTES     (BURST_BYTES),
        .N_BURSTS        (N_BURSTS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .OCW             (OCW),
        .RST_ADDR        (FB_BASE_ADDR)
    ) u_ar_issue (
        .clk           (clk),
        .rst           (rst),
        .load_i        (start_ok),
        .base_addr_i   (base_addr),
        .issue_i       (state_q == StIssue),
        .ar_ready_i    (m_arready_i),
        .r_last_hs_i   (r_last_hs),
        .araddr_o      (m_araddr_o),
        .arvalid_o     (m_arvalid_o),
        .last_ar_hs_o  (last_ar_hs),
        .outstanding_o (outstanding)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        resp_err_d = resp_err_q;
        overrun_d  = frame_start_i & busy;
`ifdef VGA_FETCH_DBL_BUF_EN
        // Toggle first so the new frame's base already uses the new buffer.
        buf_sel_d  = start_ok ? ~buf_sel_q : buf_sel_q;
        base_addr  = FB_BASE_ADDR + (buf_sel_d ? FB_ALT_OFFSET : '0);
`else
        buf_sel_d  = 1'b0;
        base_addr  = FB_BASE_ADDR;
`endif

        unique case (state_q)
            StIdle:  if (frame_start_i) state_d = StIssue;
            StIssue: if (last_ar_hs) state_d = StDrain;
            StDrain: if (r_last_hs && outstanding == OCW'(1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (start_ok) begin
            beat_d = '0;
        end else if (r_hs) begin
            // Wrap on RLAST; also wrap at the burst length so a missing RLAST
            // cannot run the counter out of range.
            beat_d = (m_rlast_i || beat_last) ? '0 : beat_q + BW'(1);
        end

        if (start_ok) begin
            resp_err_d = 1'b0;
        end else if (r_hs && ((m_rresp_i != AXI_RESP_OKAY) || (m_rlast_i != beat_last))) begin
            resp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            resp_err_q <= 1'b0;
            overrun_q  <= 1'b0;
            buf_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            resp_err_q <= resp_err_d;
            overrun_q  <= overrun_d;
            buf_sel_q  <= buf_sel_d;
        end
    end

    assign m_arlen_o       = 8'(BURST_LEN - 1);
    assign m_arsize_o      = axi_size(BYTES);
    assign m_arburst_o     = AXI_BURST_INCR;
    assign m_arprot_o      = AXI_PROT_DEFAULT;
    assign m_rready_o      = busy & pix_rdy_i;
    assign pix_valid_o     = busy & m_rvalid_i;
    assign pix_data_o      = m_rdata_i;
    assign pix_last_o      = pix_valid_o & beat_last & (state_q == StDrain)
                             & (outstanding == OCW'(1));
    assign busy_o          = busy;
    assign resp_err_o      = resp_err_q;
    assign frame_overrun_o = overrun_q;
    assign buf_sel_o       = buf_sel_q;

endmodule

// File: tb/tb_vga_axi_burst_fetch.sv
// Self-checking bench for vga_axi_burst_fetch: 16x4 frame, 16-bit pixels,
// 64-bit bus, 4-beat bursts -> 16 words in 4 bursts. A behavioural AXI slave
// returns word(addr) for every beat; the expected frame is computed directly
// from base address arithmetic.
module tb_vga_axi_burst_fetch;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned BL = 4;
    localparam int unsigned NW = 16;
    localparam int unsigned NB = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ALT  = 32'h0010_0000;

    logic          clk = 1'b0;
    logic          rst, frame_start_i;
    logic [AW-1:0] m_araddr_o;
    logic [7:0]    m_arlen_o;
    logic [2:0]    m_arsize_o, m_arprot_o;
    logic [1:0]    m_arburst_o, m_rresp_i;
    logic          m_arvalid_o, m_arready_i, m_rlast_i, m_rvalid_i, m_rready_o;
    logic [DW-1:0] m_rdata_i, pix_data_o;
    logic          pix_valid_o, pix_rdy_i, pix_last_o, busy_o, resp_err_o;
    logic          frame_overrun_o, buf_sel_o;

    always #5 clk = ~clk;

    vga_axi_burst_fetch #(
        .AXI_ADDR_WIDTH (AW), .AXI_DATA_WIDTH (DW), .BURST_LEN (BL), .MAX_OUTSTANDING (2),
        .H_PIXELS (16), .V_LINES (4), .PXL_BITS (16),
        .FB_BASE_ADDR (BASE), .FB_ALT_OFFSET (ALT)
    ) dut (
        .clk (clk), .rst (rst), .frame_start_i (frame_start_i),
        .m_araddr_o (m_araddr_o), .m_arlen_o (m_arlen_o), .m_arsize_o (m_arsize_o),
        .m_arburst_o (m_arburst_o), .m_arprot_o (m_arprot_o), .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i), .m_rdata_i (m_rdata_i), .m_rresp_i (m_rresp_i),
        .m_rlast_i (m_rlast_i), .m_rvalid_i (m_rvalid_i), .m_rready_o (m_rready_o),
        .pix_data_o (pix_data_o), .pix_valid_o (pix_valid_o), .pix_rdy_i (pix_rdy_i),
        .pix_last_o (pix_last_o), .busy_o (busy_o), .resp_err_o (resp_err_o),
        .frame_overrun_o (frame_overrun_o), .buf_sel_o (buf_sel_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus controls read by the slave model.
    bit          ar_force = 1'b1, rand_ar = 1'b0, rdy_force = 1'b1, rand_rdy = 1'b0;
    bit          r_en = 1'b1, rand_r = 1'b0, err_en = 1'b0, exp_buf = 1'b0;
    logic [31:0] seed = 32'h0, err_addr = 32'h0;

    logic [31:0] ar_q[$];
    logic [63:0] pix_q[$];
    int          last_q[$];
    logic [31:0] bq_addr[$];
    int          bq_rdy[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input logic [31:0] a);
        return {a ^ seed, ~a};
    endfunction

    function automatic logic [31:0] exp_base();
        return exp_buf ? BASE + ALT : BASE;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // AXI slave model + stream monitor. Handshakes are decided from values
    // stable at the falling edge; inputs change 1 ns after the rising edge.
    initial begin
        bit          ar_hs, r_hs, pend;
        logic [31:0] pend_addr, hs_addr, a;
        int          cyc, rbeat;
        m_arready_i = 1'b1; pix_rdy_i = 1'b1; m_rvalid_i = 1'b0; m_rdata_i = '0;
        m_rresp_i = 2'b00; m_rlast_i = 1'b0;
        cyc = 0; rbeat = 0; pend = 1'b0; pend_addr = '0;
        forever begin
            @(negedge clk);
            ar_hs   = m_arvalid_o && m_arready_i && !rst;
            r_hs    = m_rvalid_i && m_rready_o && !rst;
            hs_addr = m_araddr_o;
            if (pend) begin
                chk("ar_hold_valid", m_arvalid_o, 1);
                chk("ar_hold_addr", m_araddr_o, pend_addr);
            end
            pend      = m_arvalid_o && !m_arready_i && !rst;
            pend_addr = m_araddr_o;
            if (ar_hs) ar_q.push_back(hs_addr);
            if (r_hs) begin
                pix_q.push_back(pix_data_o);
                if (pix_last_o) last_q.push_back(pix_q.size() - 1);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                bq_addr.delete(); bq_rdy.delete();
                rbeat = 0; m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
            end else begin
                if (ar_hs) begin
                    bq_addr.push_back(hs_addr);
                    bq_rdy.push_back(cyc + 3);
                end
                if (r_hs) begin
                    rbeat++;
                    if (rbeat == BL) begin
                        rbeat = 0;
                        void'(bq_addr.pop_front());
                        void'(bq_rdy.pop_front());
                    end
                end
                if (!(m_rvalid_i && !r_hs)) begin
                    if (r_en && bq_addr.size() > 0 && bq_rdy[0] <= cyc
                        && (!rand_r || $urandom_range(0, 2) != 0)) begin
                        a = bq_addr[0] + 32'(rbeat * 8);
                        m_rvalid_i = 1'b1;
                        m_rdata_i  = word(a);
                        m_rlast_i  = (rbeat == BL - 1);
                        m_rresp_i  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
                    end else begin
                        m_rvalid_i = 1'b0;
                        m_rlast_i  = 1'b0;
                    end
                end
            end
            m_arready_i = rand_ar ? ($urandom_range(0, 2) != 0) : ar_force;
            pix_rdy_i   = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_arvalid"}, m_arvalid_o, 0);
        chk({tag, "_araddr"}, m_araddr_o, BASE);
        chk({tag, "_rready"}, m_rready_o, 0);
        chk({tag, "_pix_valid"}, pix_valid_o, 0);
        chk({tag, "_pix_last"}, pix_last_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_resp_err"}, resp_err_o, 0);
        chk({tag, "_overrun"}, frame_overrun_o, 0);
        chk({tag, "_buf_sel"}, buf_sel_o, 0);
    endtask

    task automatic start_frame();
        ar_q.delete(); pix_q.delete(); last_q.delete();
        seed = $urandom;
`ifdef VGA_FETCH_DBL_BUF_EN
        if (!busy_o) exp_buf = ~exp_buf;
`endif
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
        @(negedge clk);
        chk("start_busy", busy_o, 1);
        chk("start_arvalid", m_arvalid_o, 1);
        chk("start_resp_err_clr", resp_err_o, 0);
        chk("start_buf_sel", buf_sel_o, exp_buf);
    endtask

    task automatic wait_done(input int budget);
        int  n, last_n;
        bit  done;
        n = 0; last_n = -100; done = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (pix_valid_o && m_rready_o && pix_last_o) last_n = n;
            if (!busy_o) begin
                done = 1'b1;
                break;
            end
        end
        chk("frame_done_in_budget", done, 1);
        if (done) chk("busy_drop_after_last", n - last_n, 1);
    endtask

    task automatic check_frame();
        logic [31:0] b;
        b = exp_base();
        chk("ar_count", ar_q.size(), NB);
        for (int j = 0; j < ar_q.size() && j < NB; j++) chk("ar_addr", ar_q[j], b + 32'(j * 32));
        chk("word_count", pix_q.size(), NW);
        for (int i = 0; i < pix_q.size() && i < NW; i++) chk("word_data", pix_q[i], word(b + 32'(i * 8)));
        chk("last_count", last_q.size(), 1);
        if (last_q.size() > 0) chk("last_index", last_q[0], NW - 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] a0;
        rst = 1'b1; frame_start_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_reset("reset");
        chk("arlen", m_arlen_o, BL - 1);
        chk("arsize", m_arsize_o, 3);
        chk("arburst", m_arburst_o, 2'b01);
        chk("arprot", m_arprot_o, 3'b000);
        step();
        rst = 1'b0;

        // Free-flowing frame.
        start_frame();
        wait_done(1000);
        check_frame();
        chk("clean_resp_err", resp_err_o, 0);

        // Outstanding limit: R withheld, only two bursts may be issued.
        r_en = 1'b0;
        start_frame();
        repeat (12) @(negedge clk);
        chk("outst_ar_count", ar_q.size(), 2);
        chk("outst_arvalid_low", m_arvalid_o, 0);
        r_en = 1'b1;
        wait_done(1000);
        check_frame();

        // ARREADY low for 5 cycles: ARVALID/ARADDR must hold.
        ar_force = 1'b0;
        start_frame();
        a0 = m_araddr_o;
        chk("stall_first_addr", a0, exp_base());
        repeat (5) begin
            @(negedge clk);
            chk("stall_arvalid", m_arvalid_o, 1);
            chk("stall_araddr", m_araddr_o, a0);
        end
        ar_force = 1'b1;
        wait_done(1000);
        check_frame();

        // SLVERR on word 6: sticky flag, data still delivered.
        rand_rdy = 1'b1; rand_r = 1'b1;
        start_frame();
        err_en = 1'b1; err_addr = exp_base() + 32'd48;
        wait_done(1000);
        check_frame();
        repeat (3) begin
            @(negedge clk);
            chk("resp_err_sticky", resp_err_o, 1);
        end
        err_en = 1'b0;

        // Start request during DRAIN: overrun pulse, frame unaffected.
        start_frame();
        n = 0;
        while (ar_q.size() < NB && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_drain", ar_q.size(), NB);
        step();
        frame_start_i = 1'b1;
        step();
        frame_start_i = 1'b0;
        @(negedge clk);
        chk("overrun_pulse", frame_overrun_o, 1);
        chk("overrun_busy", busy_o, 1);
        @(negedge clk);
        chk("overrun_single", frame_overrun_o, 0);
        wait_done(1000);
        check_frame();

        // Reset while bursts are still being issued.
        rand_rdy = 1'b0; rand_r = 1'b0; ar_force = 1'b0;
        start_frame();
        step();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("midrst");
        exp_buf = 1'b0;
        step();
        rst = 1'b0; ar_force = 1'b1;

        // Randomised handshakes; first frame restarts right after its last word.
        rand_ar = 1'b1; rand_rdy = 1'b1; rand_r = 1'b1;
        start_frame();
        n = 0;
        while (n < 1500 && !(pix_valid_o && m_rready_o && pix_last_o)) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_last_seen", n < 1500, 1);
        step();
        check_frame();
        start_frame();
        wait_done(1500);
        check_frame();
        for (int f = 0; f < 2; f++) begin
            start_frame();
            wait_done(1500);
            check_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
